// File: rtl/uart_tx_queue_if.sv
// ----------------------------------------------------------------------------
// uart_tx_queue_if
// Groups the producer-side write port, the transmitter handshake and the
// status flags of uart_tx_queue into one bundle.
//   wr_en, wr_data  : byte push from the producer
//   tx_done         : end-of-frame pulse from the UART transmitter
//   clr_err         : clears the sticky error flags
//   tx_data, tx_send: byte and one-cycle start pulse toward the transmitter
//   full, empty,
//   count, busy     : queue and sequencer status
//   overflow,
//   tx_timeout      : sticky error flags
// The slave modport is the queue itself; master is whoever drives it.
// ----------------------------------------------------------------------------
interface uart_tx_queue_if #(
   parameter int AW = 4
);
   logic          wr_en;
   logic [7:0]    wr_data;
   logic          tx_done;
   logic          clr_err;
   logic [7:0]    tx_data;
   logic          tx_send;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          busy;
   logic          overflow;
   logic          tx_timeout;

   modport slave (
      input  wr_en, wr_data, tx_done, clr_err,
      output tx_data, tx_send, full, empty, count, busy, overflow, tx_timeout
   );

   modport master (
      output wr_en, wr_data, tx_done, clr_err,
      input  tx_data, tx_send, full, empty, count, busy, overflow, tx_timeout
   );
endinterface

// File: rtl/uart_tx_queue.sv
// ----------------------------------------------------------------------------
// uart_tx_queue
// Byte FIFO plus a two-state send sequencer in front of the UART transmitter.
// Bytes pushed at any rate are buffered and launched one at a time: each
// launch is a one-cycle tx_send pulse with tx_data held, after which the
// sequencer waits for tx_done (or a timeout) before launching the next byte.
// Ports:
//   clock   : system clock, rising edge
//   n_reset : asynchronous active-low reset
//   bus     : uart_tx_queue_if slave modport (write port, transmitter
//             handshake, status and sticky error flags)
// ----------------------------------------------------------------------------
module uart_tx_queue #(
   parameter int DEPTH       = 16,
   parameter int AW          = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic            clock,
   input  logic            n_reset,
   uart_tx_queue_if.slave  bus
);

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } state_t;

   logic [7:0]    mem [DEPTH];

   state_t        state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          full_q, empty_q;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_send_q, tx_send_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          overflow_q, overflow_d;
   logic          timeout_q, timeout_d;

   logic          pop;
   logic          push;
   logic          timerExpired;
   logic          overflowSet;
   logic          timeoutSet;

   // A pop frees a slot on the same edge, so a full queue still accepts a
   // write while the sequencer is launching.
   assign pop          = (state_q == ST_IDLE) && !empty_q;
   assign push         = bus.wr_en && (!full_q || pop);
   assign timerExpired = (timer_q == TW'(TIMEOUT_CYC - 1));
   assign overflowSet  = bus.wr_en && full_q && !pop;
   assign timeoutSet   = (state_q == ST_WAIT) && !bus.tx_done && timerExpired;

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.wr_data;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (!empty_q) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.tx_done || timerExpired) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      tx_data_d  = tx_data_q;
      tx_send_d  = pop;
      timer_d    = timer_q;
      overflow_d = overflowSet || (overflow_q && !bus.clr_err);
      timeout_d  = timeoutSet || (timeout_q && !bus.clr_err);

      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + AW'(1);
         tx_data_d = mem[rd_ptr_q];
      end

      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      if (pop) begin
         timer_d = '0;
      end else if ((state_q == ST_WAIT) && !bus.tx_done && !timerExpired) begin
         timer_d = timer_q + TW'(1);
      end
   end

   // full/empty are registered from the next-cycle count so they line up
   // with count itself.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         tx_data_q  <= 8'h00;
         tx_send_q  <= 1'b0;
         timer_q    <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= (count_d == (AW+1)'(DEPTH));
         empty_q    <= (count_d == '0);
         tx_data_q  <= tx_data_d;
         tx_send_q  <= tx_send_d;
         timer_q    <= timer_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.tx_data    = tx_data_q;
   assign bus.tx_send    = tx_send_q;
   assign bus.full       = full_q;
   assign bus.empty      = empty_q;
   assign bus.count      = count_q;
   assign bus.busy       = (state_q == ST_WAIT);
   assign bus.overflow   = overflow_q;
   assign bus.tx_timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_queue
// Directed bench for uart_tx_queue. Two instances share clock and reset:
// qa/dutA uses the default timeout for the functional sequences, and
// qb/dutB uses a 20-cycle timeout for the abandoned-frame case. Inputs are
// driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_tx_queue;

   logic clock;
   logic n_reset;
   int   total = 0;
   int   bad   = 0;
   int   edges;
   int   sends;

   uart_tx_queue_if #(.AW(4)) qa ();
   uart_tx_queue_if #(.AW(4)) qb ();

   uart_tx_queue #(.DEPTH(16), .AW(4), .TIMEOUT_CYC(200000)) dutA (
      .clock   (clock),
      .n_reset (n_reset),
      .bus     (qa.slave)
   );

   uart_tx_queue #(.DEPTH(16), .AW(4), .TIMEOUT_CYC(20)) dutB (
      .clock   (clock),
      .n_reset (n_reset),
      .bus     (qb.slave)
   );

   // 10-unit clock period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Drives the write port and handshake inputs of the default-timeout queue
   task automatic applyStimulus(input logic we, input logic [7:0] data,
                                input logic done, input logic clr);
      qa.wr_en   = we;
      qa.wr_data = data;
      qa.tx_done = done;
      qa.clr_err = clr;
   endtask

   // Same for the short-timeout queue
   task automatic applyStimulusT(input logic we, input logic [7:0] data,
                                 input logic done, input logic clr);
      qb.wr_en   = we;
      qb.wr_data = data;
      qb.tx_done = done;
      qb.clr_err = clr;
   endtask

   // One comparison: counts it, and counts and reports a failure
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Linear directed sequence
   initial begin
      n_reset = 1'b0;
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      applyStimulusT(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(negedge clock);

      // Reset state
      checkOutput("rst_count", 32'(qa.count), 0);
      checkOutput("rst_empty", 32'(qa.empty), 1);
      checkOutput("rst_full", 32'(qa.full), 0);
      checkOutput("rst_send", 32'(qa.tx_send), 0);
      checkOutput("rst_busy", 32'(qa.busy), 0);
      checkOutput("rst_data", 32'(qa.tx_data), 0);
      checkOutput("rst_flags", {30'd0, qa.overflow, qa.tx_timeout}, 0);
      n_reset = 1'b1;
      @(negedge clock);

      // Single byte
      $display("[TB] single byte");
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("sb_count_k", 32'(qa.count), 1);
      checkOutput("sb_send_k", 32'(qa.tx_send), 0);
      @(negedge clock);
      checkOutput("sb_send_k1", 32'(qa.tx_send), 1);
      checkOutput("sb_data_k1", 32'(qa.tx_data), 32'h41);
      checkOutput("sb_busy_k1", 32'(qa.busy), 1);
      checkOutput("sb_empty_k1", 32'(qa.empty), 1);
      @(negedge clock);
      checkOutput("sb_send_k2", 32'(qa.tx_send), 0);
      checkOutput("sb_busy_k2", 32'(qa.busy), 1);
      repeat (47) @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("sb_busy_done", 32'(qa.busy), 0);
      checkOutput("sb_empty_done", 32'(qa.empty), 1);

      // Ordering and spacing
      $display("[TB] ordering");
      @(negedge clock);
      applyStimulus(1'b1, 8'h41, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("ord_send0", 32'(qa.tx_send), 1);
      checkOutput("ord_data0", 32'(qa.tx_data), 32'h41);
      applyStimulus(1'b1, 8'h43, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ord_count", 32'(qa.count), 3);
      for (int i = 0; i < 4; i++) begin
         repeat (98) @(negedge clock);
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
         @(negedge clock);
         applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
         if (i < 3) begin
            edges = 1;
            while (edges < 10) begin
               @(negedge clock);
               edges++;
               if (qa.tx_send) break;
            end
            checkOutput($sformatf("ord_gap%0d", i), 32'(edges), 2);
            checkOutput($sformatf("ord_byte%0d", i + 1), 32'(qa.tx_data), 32'h42 + 32'(i));
         end else begin
            checkOutput("ord_busy_end", 32'(qa.busy), 0);
            checkOutput("ord_empty_end", 32'(qa.empty), 1);
         end
      end

      // Overflow: 18-byte burst, clr_err on the dropping edge must lose to the set
      $display("[TB] overflow");
      @(negedge clock);
      for (int i = 0; i < 18; i++) begin
         if (i == 17) begin
            checkOutput("ovf_full_pre", 32'(qa.full), 1);
            checkOutput("ovf_flag_pre", 32'(qa.overflow), 0);
         end
         applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0, (i == 17));
         @(negedge clock);
      end
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ovf_count", 32'(qa.count), 16);
      checkOutput("ovf_full", 32'(qa.full), 1);
      checkOutput("ovf_flag", 32'(qa.overflow), 1);
      checkOutput("ovf_busy", 32'(qa.busy), 1);
      checkOutput("ovf_inflight", 32'(qa.tx_data), 32'h60);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("ovf_clr", 32'(qa.overflow), 0);
      checkOutput("ovf_count_clr", 32'(qa.count), 16);

      // Push and pop on the same edge while full
      $display("[TB] push/pop when full");
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
      checkOutput("pp_full_pre", 32'(qa.full), 1);
      checkOutput("pp_busy_pre", 32'(qa.busy), 0);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("pp_count", 32'(qa.count), 16);
      checkOutput("pp_full", 32'(qa.full), 1);
      checkOutput("pp_overflow", 32'(qa.overflow), 0);
      checkOutput("pp_send", 32'(qa.tx_send), 1);
      checkOutput("pp_data", 32'(qa.tx_data), 32'h61);

      // Timeout on the 20-cycle instance
      $display("[TB] timeout");
      applyStimulusT(1'b1, 8'h55, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulusT(1'b1, 8'h56, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulusT(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("to_send", 32'(qb.tx_send), 1);
      checkOutput("to_data", 32'(qb.tx_data), 32'h55);
      repeat (19) @(negedge clock);
      checkOutput("to_busy_19", 32'(qb.busy), 1);
      checkOutput("to_flag_19", 32'(qb.tx_timeout), 0);
      @(negedge clock);
      checkOutput("to_busy_20", 32'(qb.busy), 0);
      checkOutput("to_flag_20", 32'(qb.tx_timeout), 1);
      @(negedge clock);
      checkOutput("to_next_send", 32'(qb.tx_send), 1);
      checkOutput("to_next_data", 32'(qb.tx_data), 32'h56);
      applyStimulusT(1'b0, 8'h00, 1'b0, 1'b1);
      @(negedge clock);
      applyStimulusT(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("to_clr", 32'(qb.tx_timeout), 0);

      // Reset mid-frame with 3 bytes queued
      $display("[TB] reset mid-frame");
      n_reset = 1'b0;
      @(negedge clock);
      n_reset = 1'b1;
      @(negedge clock);
      applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("mr_count_pre", 32'(qa.count), 3);
      checkOutput("mr_busy_pre", 32'(qa.busy), 1);
      #2 n_reset = 1'b0;
      #1;
      checkOutput("mr_count", 32'(qa.count), 0);
      checkOutput("mr_empty", 32'(qa.empty), 1);
      checkOutput("mr_send", 32'(qa.tx_send), 0);
      checkOutput("mr_busy", 32'(qa.busy), 0);
      checkOutput("mr_data", 32'(qa.tx_data), 0);
      @(negedge clock);
      n_reset = 1'b1;
      sends = 0;
      repeat (10) begin
         @(negedge clock);
         if (qa.tx_send) sends++;
      end
      checkOutput("mr_nosend", 32'(sends), 0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
      @(negedge clock);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      @(negedge clock);
      checkOutput("mr_relaunch_send", 32'(qa.tx_send), 1);
      checkOutput("mr_relaunch_data", 32'(qa.tx_data), 32'h77);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
